// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared sizes, accumulator type and FSM state for the bit-serial dot product
package dot_pkg;

  localparam int LANES = 64;
  localparam int WBITS = 16;
  localparam int PCW   = $clog2(LANES) + 1;
  localparam int ACCW  = WBITS + $clog2(LANES) + 1;
  localparam int CNTW  = $clog2(WBITS);

  typedef logic signed [ACCW-1:0] acc_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/popcount64.sv
// rtl/popcount64.sv - combinational population count of LANES bits
module popcount64
  import dot_pkg::*;
(
  input  logic [LANES-1:0] in_i,
  output logic [PCW-1:0]   count_o
);

  // Two-level tree: eight 8-bit groups, then the group sums.
  logic [3:0] grp [8];

  always_comb begin
    count_o = '0;
    for (int g = 0; g < 8; g++) begin
      grp[g] = '0;
      for (int b = 0; b < 8; b++) begin
        grp[g] = grp[g] + 4'(in_i[g*8+b]);
      end
    end
    for (int g = 0; g < 8; g++) begin
      count_o = count_o + PCW'(grp[g]);
    end
  end

endmodule

// File: rtl/bitserial_dot_accum.sv
// rtl/bitserial_dot_accum.sv - MSB-first bit-serial signed dot product of 64 weight lanes
module bitserial_dot_accum
  import dot_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             bit_en,
  input  logic [LANES-1:0] a_bits,
  input  logic [LANES-1:0] act,
  output logic             busy,
  output logic [ACCW-1:0]  result,
  output logic             result_valid
);

  state_t           state_q;
  logic [CNTW-1:0]  cnt_q;
  logic [LANES-1:0] act_q;
  acc_t             acc_q;
  acc_t             acc_d;
  logic             busy_q;
  acc_t             result_q;
  logic             result_valid_q;

  logic [LANES-1:0] pc_in;
  logic [PCW-1:0]   pc;
  acc_t             pc_ext;
  logic             start_edge;

  // The mask is not yet in act_q on the MSB edge, so take it straight from the port.
  assign pc_in      = (start ? act : act_q) & a_bits;
  assign pc_ext     = acc_t'({{(ACCW-PCW){1'b0}}, pc});
  assign start_edge = start & bit_en;
  assign acc_d      = (acc_q <<< 1) + pc_ext;

  popcount64 u_popcount (
    .in_i    (pc_in),
    .count_o (pc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      act_q          <= '0;
      acc_q          <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (start_edge) begin
        // MSB has weight -2^(WBITS-1): seed with the negated count; also aborts any word in flight.
        act_q   <= act;
        acc_q   <= acc_t'(0) - pc_ext;
        cnt_q   <= CNTW'(WBITS - 2);
        state_q <= ACCUM;
        busy_q  <= 1'b1;
      end else if (state_q == ACCUM && bit_en) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_q       <= acc_d;
          result_valid_q <= 1'b1;
          state_q        <= IDLE;
          busy_q         <= 1'b0;
        end
      end
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
